// File: rtl/alu_writeback.sv
// alu_writeback: waits RESULT_LAT cycles for the ALU, then commits the result and masked PSW flags; ALU_WB_FORWARD_EN adds bypass outputs
module alu_writeback #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 3,
  parameter int RESULT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [4:0]        instr,
  input  logic [REG_AW-1:0] dst_reg,
  input  logic [DATA_W-1:0] psw_cur,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_psw,
  input  logic              rf_busy,
  output logic              in_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              psw_we,
  output logic [DATA_W-1:0] psw_wdata,
  output logic              wb_done,
  output logic              err_illegal,
`ifdef ALU_WB_FORWARD_EN
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              err_overrun
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, COMMIT = 2'd2;
  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [4:0]        instr_q;
  logic [REG_AW-1:0] dst_q;
  logic [DATA_W-1:0] psw_q, res_q, apsw_q, mask;
  logic              illegal, wr_ok, in_commit, commit;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      instr_q     <= '0;
      dst_q       <= '0;
      psw_q       <= '0;
      res_q       <= '0;
      apsw_q      <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (alu_valid && state != IDLE) err_overrun <= 1'b1;
      if (state == IDLE && alu_valid) begin
        state   <= WAIT;
        cnt     <= 4'(RESULT_LAT);
        instr_q <= instr;
        dst_q   <= dst_reg;
        psw_q   <= psw_cur;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          res_q  <= alu_result;
          apsw_q <= alu_psw;
          state  <= COMMIT;
        end
      end else if (state == COMMIT && !rf_busy) begin
        state <= IDLE;
      end
    end
  end
  // XM-23 flag groups: arithmetic VNZC, logical NZ, decimal/rotate C, shift none
  always_comb begin
    illegal = instr_q[4:2] == 3'b111;
    wr_ok   = !illegal && instr_q[4:1] != 4'b0101 && instr_q[4:1] != 4'b1001;
    mask    = (instr_q[4:3] == 2'b00 || instr_q[4:1] == 4'b0101) ? DATA_W'(5'h17) :
              (instr_q[4:1] == 4'b0100 || instr_q[4:1] == 4'b1101) ? DATA_W'(5'h01) :
              (instr_q >= 5'b01100 && instr_q <= 5'b10111) ? DATA_W'(5'h06) : '0;
  end
  assign in_commit   = state == COMMIT;
  assign commit      = in_commit && !rf_busy;
  assign in_ready    = state == IDLE;
  assign rf_we       = commit && wr_ok;
  assign psw_we      = commit && mask != '0;
  assign wb_done     = commit;
  assign err_illegal = commit && illegal;
  assign rf_waddr    = in_commit ? dst_q : '0;
  assign rf_wdata    = in_commit ? res_q : '0;
  assign psw_wdata   = in_commit ? ((psw_q & ~mask) | (apsw_q & mask)) : '0;
`ifdef ALU_WB_FORWARD_EN
  assign fwd_valid = in_commit && wr_ok;
  assign fwd_reg   = fwd_valid ? dst_q : '0;
  assign fwd_data  = fwd_valid ? res_q : '0;
`endif
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed checks of alu_writeback at RESULT_LAT=2
module tb_alu_writeback;
  logic        clk = 0, rst_n = 0, alu_valid = 0, rf_busy = 0;
  logic [4:0]  instr = 0;
  logic [2:0]  dst_reg = 0;
  logic [15:0] psw_cur = 0, alu_result = 0, alu_psw = 0;
  logic        in_ready, rf_we, psw_we, wb_done, err_illegal, err_overrun;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata, psw_wdata;
`ifdef ALU_WB_FORWARD_EN
  logic        fwd_valid;
  logic [2:0]  fwd_reg;
  logic [15:0] fwd_data;
`endif
  int checks = 0, fails = 0;
  alu_writeback dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .instr(instr), .dst_reg(dst_reg),
    .psw_cur(psw_cur), .alu_result(alu_result), .alu_psw(alu_psw), .rf_busy(rf_busy),
    .in_ready(in_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .psw_we(psw_we), .psw_wdata(psw_wdata), .wb_done(wb_done), .err_illegal(err_illegal),
`ifdef ALU_WB_FORWARD_EN
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
`endif
    .err_overrun(err_overrun));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] i, input logic [2:0] d, input logic [15:0] pc, input logic [15:0] res, input logic [15:0] ap);
    alu_valid = 1; instr = i; dst_reg = d; psw_cur = pc; alu_result = res; alu_psw = ap;
    step();
    alu_valid = 0;
    chk("busy_after_issue", 16'(in_ready), 16'd0);
    step();
    chk("no_early_commit", 16'(wb_done), 16'd0);
    step();
  endtask
  initial begin
    step(); step();
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_strobes", {11'd0, rf_we, psw_we, wb_done, err_illegal, err_overrun}, 16'd0);
    chk("rst_data", rf_wdata | psw_wdata | 16'(rf_waddr), 16'd0);
    rst_n = 1;
    step();
    issue(5'b00000, 3'd3, 16'h0008, 16'h8000, 16'h0014);
    chk("add_rf_we", 16'(rf_we), 16'd1);
    chk("add_waddr", 16'(rf_waddr), 16'd3);
    chk("add_wdata", rf_wdata, 16'h8000);
    chk("add_psw_we", 16'(psw_we), 16'd1);
    chk("add_psw", psw_wdata, 16'h001C);
    chk("add_done", 16'(wb_done), 16'd1);
    step();
    chk("add_idle", {14'd0, in_ready, wb_done}, 16'd2);
    issue(5'b01010, 3'd1, 16'h0000, 16'h5555, 16'h0003);
    chk("cmp_rf_we", 16'(rf_we), 16'd0);
    chk("cmp_psw_we", 16'(psw_we), 16'd1);
    chk("cmp_psw", psw_wdata, 16'h0003);
    chk("cmp_done", 16'(wb_done), 16'd1);
    step();
    issue(5'b11000, 3'd2, 16'h0005, 16'hC001, 16'h001F);
    chk("sra_rf_we", 16'(rf_we), 16'd1);
    chk("sra_wdata", rf_wdata, 16'hC001);
    chk("sra_waddr", 16'(rf_waddr), 16'd2);
    chk("sra_psw_we", 16'(psw_we), 16'd0);
    chk("sra_psw_keep", psw_wdata, 16'h0005);
    step();
    alu_valid = 1; instr = 5'b01100; dst_reg = 3'd5; psw_cur = 16'h0019; alu_result = 16'h1234; alu_psw = 16'h0006;
    step();
    instr = 5'b11110; dst_reg = 3'd7;
    step();
    alu_valid = 0; rf_busy = 1;
    chk("overrun_set", 16'(err_overrun), 16'd1);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("busy_no_write", {13'd0, rf_we, psw_we, wb_done}, 16'd0);
      chk("busy_hold_data", rf_wdata, 16'h1234);
      step();
    end
    rf_busy = 0;
    #1;
    chk("xor_rf_we", 16'(rf_we), 16'd1);
    chk("xor_waddr", 16'(rf_waddr), 16'd5);
    chk("xor_psw", psw_wdata, 16'h001F);
    chk("xor_not_illegal", 16'(err_illegal), 16'd0);
    step();
    chk("overrun_sticky", {14'd0, err_overrun, in_ready}, 16'd3);
    issue(5'b11110, 3'd4, 16'h0000, 16'hFFFF, 16'h001F);
    chk("ill_writes", {14'd0, rf_we, psw_we}, 16'd0);
    chk("ill_done", {14'd0, wb_done, err_illegal}, 16'd3);
    step();
    chk("ill_pulse", 16'(err_illegal), 16'd0);
    alu_valid = 1; instr = 5'b01101; dst_reg = 3'd6; alu_result = 16'hABCD;
    step();
    alu_valid = 0; rst_n = 0;
    step();
    rst_n = 1;
    chk("rst_mid_ready", 16'(in_ready), 16'd1);
    chk("rst_mid_out", {11'd0, rf_we, psw_we, wb_done, err_illegal, err_overrun}, 16'd0);
    chk("rst_mid_data", rf_wdata | psw_wdata | 16'(rf_waddr), 16'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_no_write", {14'd0, rf_we, wb_done}, 16'd0);
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
